regfile_write_arbiter: RTL and testbench

Shares the register file's single write port between the ALU writeback and the load writeback paths. Runs the 5-phase register-file sequence (read in phase 2, write in phase 4) and buffers each requester in a small FIFO. Drives one write per period and exposes a pending-write scoreboard to the hazard unit. Sits between the execute/memory stages and `register_file`, driving its `write_register`, `write_data` and `RegWrite` inputs.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_write_arbiter_if.sv | 33 +++
 rtl/wb_fifo.sv | 64 ++++++
 rtl/regfile_write_arbiter.sv | 120 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, defaults and writeback request type for the register-file
// write arbiter and its per-requester FIFOs.
package regfile_pkg;

  localparam int REG_ADDR_W      = 5;
  localparam int DATA_W          = 32;
  localparam int PHASE_W         = 3;
  localparam int NUM_REGS        = 32;
  localparam int DEF_PHASES      = 5;
  localparam int DEF_WRITE_PHASE = 4;
  localparam int DEF_DEPTH       = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  // Values double as requester indices: 0 = ALU, 1 = MEM.
  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request channels (ALU, MEM) plus the register-file write port
// and hazard-unit status driven by the arbiter.
interface regfile_write_arbiter_if;
  import regfile_pkg::*;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0]     alu_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] mem_reg;
  logic [DATA_W-1:0]     mem_data;
  logic [REG_ADDR_W-1:0] write_register;
  logic [DATA_W-1:0]     write_data;
  logic                  RegWrite;
  logic [PHASE_W-1:0]    phase;
  logic [NUM_REGS-1:0]   pending_mask;
  logic                  busy;

  modport master (
    output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
    input  alu_ready, mem_ready, write_register, write_data, RegWrite,
           phase, pending_mask, busy
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
    output alu_ready, mem_ready, write_register, write_data, RegWrite,
           phase, pending_mask, busy
  );

endinterface

// File: rtl/wb_fifo.sv
// Small writeback FIFO with same-edge push/pop and a per-entry valid/reg
// view so the arbiter can build its pending-write scoreboard.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             push,
  input  wb_req_t                          push_req,
  input  logic                             pop,
  output wb_req_t                          head,
  output logic [CNT_W-1:0]                 count,
  output logic                             ready,
  output logic [DEPTH-1:0]                 entry_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_reg
);

  wb_req_t          storage_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  always_comb begin
    wr_ptr_next = push ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
    rd_ptr_next = pop  ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    count_next  = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) storage_reg[i] <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (push) storage_reg[wr_ptr_reg] <= push_req;
    end
  end

  assign head  = storage_reg[rd_ptr_reg];
  assign count = count_reg;
  assign ready = (count_reg < CNT_W'(DEPTH));

  // Entry gi is live when its distance from the read pointer is below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [PTR_W-1:0] offset;
    assign offset          = PTR_W'(gi) - rd_ptr_reg;
    assign entry_valid[gi] = ({1'b0, offset} < count_reg);
    assign entry_reg[gi]   = storage_reg[gi].reg_addr;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's write port between ALU and load writeback:
// phase counter, round-robin grant in the write phase, pending-write mask.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int PHASES      = DEF_PHASES,
  parameter int WRITE_PHASE = DEF_WRITE_PHASE,
  parameter int DEPTH       = DEF_DEPTH
) (
  input  logic                    clock,
  input  logic                    reset_n,
  regfile_write_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [1:0]                       req_valid, req_ready, req_push, req_pop, req_nonempty;
  wb_req_t                          req_in   [2];
  wb_req_t                          req_head [2];
  logic [CNT_W-1:0]                 req_count [2];
  logic [DEPTH-1:0]                 entry_valid [2];
  logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_reg [2];

  logic [PHASE_W-1:0]    phase_reg, phase_next;
  logic                  reg_write_reg, reg_write_next;
  logic [REG_ADDR_W-1:0] write_register_reg, write_register_next;
  logic [DATA_W-1:0]     write_data_reg, write_data_next;
  grant_t                last_grant_reg, last_grant_next;
  grant_t                grant_sel;
  logic                  grant_fire;
  wb_req_t               grant_req;
  logic [NUM_REGS-1:0]   pending_mask;

  assign req_valid = {bus.mem_valid, bus.alu_valid};
  assign req_in[0] = '{reg_addr: bus.alu_reg, data: bus.alu_data};
  assign req_in[1] = '{reg_addr: bus.mem_reg, data: bus.mem_data};

  // Register 0 is hardwired, so its writes are acknowledged but never queued.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign req_push[gi]     = req_valid[gi] && req_ready[gi] && (req_in[gi].reg_addr != '0);
    assign req_nonempty[gi] = (req_count[gi] != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock       (clock),
      .reset_n     (reset_n),
      .push        (req_push[gi]),
      .push_req    (req_in[gi]),
      .pop         (req_pop[gi]),
      .head        (req_head[gi]),
      .count       (req_count[gi]),
      .ready       (req_ready[gi]),
      .entry_valid (entry_valid[gi]),
      .entry_reg   (entry_reg[gi])
    );
  end

  always_comb begin
    grant_fire = 1'b0;
    grant_sel  = GRANT_ALU;
    if ((phase_reg == PHASE_W'(WRITE_PHASE - 1)) && (|req_nonempty)) begin
      grant_fire = 1'b1;
      if (&req_nonempty)
        grant_sel = (last_grant_reg == GRANT_ALU) ? GRANT_MEM : GRANT_ALU;
      else
        grant_sel = req_nonempty[1] ? GRANT_MEM : GRANT_ALU;
    end
  end

  assign req_pop   = grant_fire ? ((grant_sel == GRANT_MEM) ? 2'b10 : 2'b01) : 2'b00;
  assign grant_req = (grant_sel == GRANT_MEM) ? req_head[1] : req_head[0];

  always_comb begin
    phase_next          = (phase_reg == PHASE_W'(PHASES - 1)) ? '0 : phase_reg + PHASE_W'(1);
    reg_write_next      = reg_write_reg;
    write_register_next = write_register_reg;
    write_data_next     = write_data_reg;
    last_grant_next     = last_grant_reg;
    if (phase_reg == PHASE_W'(WRITE_PHASE)) reg_write_next = 1'b0;
    if (grant_fire) begin
      reg_write_next      = 1'b1;
      write_register_next = grant_req.reg_addr;
      write_data_next     = grant_req.data;
      last_grant_next     = grant_sel;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_reg          <= '0;
      reg_write_reg      <= 1'b0;
      write_register_reg <= '0;
      write_data_reg     <= '0;
      last_grant_reg     <= GRANT_ALU;
    end else begin
      phase_reg          <= phase_next;
      reg_write_reg      <= reg_write_next;
      write_register_reg <= write_register_next;
      write_data_reg     <= write_data_next;
      last_grant_reg     <= last_grant_next;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int r = 0; r < 2; r++)
      for (int e = 0; e < DEPTH; e++)
        if (entry_valid[r][e]) pending_mask[entry_reg[r][e]] = 1'b1;
    if (reg_write_reg) pending_mask[write_register_reg] = 1'b1;
  end

  assign bus.alu_ready      = req_ready[0];
  assign bus.mem_ready      = req_ready[1];
  assign bus.write_register = write_register_reg;
  assign bus.write_data     = write_data_reg;
  assign bus.RegWrite       = reg_write_reg;
  assign bus.phase          = phase_reg;
  assign bus.pending_mask   = pending_mask;
  assign bus.busy           = (|req_nonempty) || reg_write_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, single write, tie,
// backpressure, zero register and reset during a write.
module tb_regfile_write_arbiter;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(.PHASES(5), .WRITE_PHASE(4), .DEPTH(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_phase(input logic [2:0] p);
    int n = 0;
    while (bus.phase !== p && n < 10) begin
      step();
      n++;
    end
    vectors++;
    if (bus.phase !== p) begin
      miscompares++;
      $display("FAIL wait_phase: phase=%0d required %0d (timeout)", bus.phase, p);
    end
  endtask

  task automatic clear_inputs();
    bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_reg = '0; bus.mem_data = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    vectors++;
    if (bus.phase !== 3'd0 || bus.RegWrite !== 1'b0 || bus.write_register !== 5'd0 ||
        bus.write_data !== 32'd0 || bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b1 ||
        bus.pending_mask !== 32'd0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: phase=%0d RegWrite=%0b wr=%0d wd=%h ar=%0b mr=%0b mask=%h busy=%0b required 0 0 0 0 1 1 0 0",
               tag, bus.phase, bus.RegWrite, bus.write_register, bus.write_data,
               bus.alu_ready, bus.mem_ready, bus.pending_mask, bus.busy);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    step();
    step();
    check_idle_outputs("reset_values");
    reset_n = 1'b1;
  endtask

  task automatic test_single_alu();
    wait_phase(3'd2);
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd5; bus.alu_data = 32'hDEADBEEF;
    step();
    clear_inputs();
    vectors++;
    if (bus.pending_mask !== 32'h20 || bus.RegWrite !== 1'b0) begin
      miscompares++;
      $display("FAIL single_queued: mask=%h RegWrite=%0b required 00000020 0", bus.pending_mask, bus.RegWrite);
    end
    step();
    vectors++;
    if (bus.phase !== 3'd4 || bus.RegWrite !== 1'b1 || bus.write_register !== 5'd5 ||
        bus.write_data !== 32'hDEADBEEF || bus.pending_mask !== 32'h20) begin
      miscompares++;
      $display("FAIL single_write: phase=%0d RegWrite=%0b wr=%0d wd=%h mask=%h required 4 1 5 deadbeef 00000020",
               bus.phase, bus.RegWrite, bus.write_register, bus.write_data, bus.pending_mask);
    end
    step();
    vectors++;
    if (bus.RegWrite !== 1'b0 || bus.pending_mask !== 32'd0 || bus.write_register !== 5'd5 ||
        bus.write_data !== 32'hDEADBEEF || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_commit: RegWrite=%0b mask=%h wr=%0d wd=%h busy=%0b required 0 0 5 deadbeef 0",
               bus.RegWrite, bus.pending_mask, bus.write_register, bus.write_data, bus.busy);
    end
  endtask

  task automatic test_tie();
    wait_phase(3'd2);
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd1; bus.alu_data = 32'h11;
    bus.mem_valid = 1'b1; bus.mem_reg = 5'd2; bus.mem_data = 32'h22;
    step();
    clear_inputs();
    vectors++;
    if (bus.pending_mask !== 32'h6) begin
      miscompares++;
      $display("FAIL tie_mask: mask=%h required 00000006", bus.pending_mask);
    end
    step();
    vectors++;
    if (bus.RegWrite !== 1'b1 || bus.write_register !== 5'd2 || bus.write_data !== 32'h22) begin
      miscompares++;
      $display("FAIL tie_first: RegWrite=%0b wr=%0d wd=%h required 1 2 00000022",
               bus.RegWrite, bus.write_register, bus.write_data);
    end
    for (int i = 0; i < 4; i++) step();
    vectors++;
    if (bus.RegWrite !== 1'b0 || bus.pending_mask !== 32'h2) begin
      miscompares++;
      $display("FAIL tie_gap: RegWrite=%0b mask=%h required 0 00000002", bus.RegWrite, bus.pending_mask);
    end
    step();
    vectors++;
    if (bus.RegWrite !== 1'b1 || bus.write_register !== 5'd1 || bus.write_data !== 32'h11) begin
      miscompares++;
      $display("FAIL tie_second: RegWrite=%0b wr=%0d wd=%h required 1 1 00000011",
               bus.RegWrite, bus.write_register, bus.write_data);
    end
    step();
  endtask

  task automatic test_backpressure();
    wait_phase(3'd0);
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd3; bus.alu_data = 32'h33;
    step();
    vectors++;
    if (bus.alu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_ready_after_1: alu_ready=%0b required 1", bus.alu_ready);
    end
    bus.alu_reg = 5'd4; bus.alu_data = 32'h44;
    step();
    vectors++;
    if (bus.alu_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_ready_after_2: alu_ready=%0b required 0", bus.alu_ready);
    end
    bus.alu_reg = 5'd6; bus.alu_data = 32'h66;
    step();
    vectors++;
    if (bus.alu_ready !== 1'b0 || bus.pending_mask !== 32'h18) begin
      miscompares++;
      $display("FAIL bp_held_off: alu_ready=%0b mask=%h required 0 00000018", bus.alu_ready, bus.pending_mask);
    end
    step();
    vectors++;
    if (bus.RegWrite !== 1'b1 || bus.write_register !== 5'd3 || bus.alu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_drain: RegWrite=%0b wr=%0d alu_ready=%0b required 1 3 1",
               bus.RegWrite, bus.write_register, bus.alu_ready);
    end
    step();
    bus.alu_valid = 1'b0;
    vectors++;
    if (bus.alu_ready !== 1'b0 || bus.pending_mask !== 32'h50) begin
      miscompares++;
      $display("FAIL bp_refill: alu_ready=%0b mask=%h required 0 00000050", bus.alu_ready, bus.pending_mask);
    end
    wait_phase(3'd4);
    wait_phase(3'd3);
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd7; bus.alu_data = 32'h77;
    step();
    clear_inputs();
    vectors++;
    if (bus.alu_ready !== 1'b1 || bus.RegWrite !== 1'b1 || bus.write_register !== 5'd6 ||
        bus.pending_mask !== 32'hC0) begin
      miscompares++;
      $display("FAIL bp_push_pop: alu_ready=%0b RegWrite=%0b wr=%0d mask=%h required 1 1 6 000000c0",
               bus.alu_ready, bus.RegWrite, bus.write_register, bus.pending_mask);
    end
    for (int i = 0; i < 5; i++) step();
    vectors++;
    if (bus.RegWrite !== 1'b1 || bus.write_register !== 5'd7 || bus.write_data !== 32'h77) begin
      miscompares++;
      $display("FAIL bp_last: RegWrite=%0b wr=%0d wd=%h required 1 7 00000077",
               bus.RegWrite, bus.write_register, bus.write_data);
    end
    step();
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_idle: busy=%0b required 0", bus.busy);
    end
  endtask

  task automatic test_zero_reg();
    wait_phase(3'd2);
    bus.mem_valid = 1'b1; bus.mem_reg = 5'd0; bus.mem_data = 32'hBAD;
    step();
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (bus.mem_ready !== 1'b1 || bus.pending_mask !== 32'd0 || bus.RegWrite !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_reg[%0d]: mem_ready=%0b mask=%h RegWrite=%0b busy=%0b required 1 0 0 0",
                 i, bus.mem_ready, bus.pending_mask, bus.RegWrite, bus.busy);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_write();
    wait_phase(3'd0);
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd8;  bus.alu_data = 32'h88;
    bus.mem_valid = 1'b1; bus.mem_reg = 5'd9;  bus.mem_data = 32'h99;
    step();
    bus.alu_reg = 5'd10; bus.alu_data = 32'hAA;
    bus.mem_reg = 5'd11; bus.mem_data = 32'hBB;
    step();
    clear_inputs();
    step();
    step();
    vectors++;
    if (bus.phase !== 3'd4 || bus.RegWrite !== 1'b1 || bus.write_register !== 5'd9 ||
        bus.pending_mask !== 32'hF00) begin
      miscompares++;
      $display("FAIL rst_precond: phase=%0d RegWrite=%0b wr=%0d mask=%h required 4 1 9 00000f00",
               bus.phase, bus.RegWrite, bus.write_register, bus.pending_mask);
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("rst_immediate");
    step();
    check_idle_outputs("rst_held");
    reset_n = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd12; bus.alu_data = 32'hC12;
    bus.mem_valid = 1'b1; bus.mem_reg = 5'd13; bus.mem_data = 32'hC13;
    step();
    clear_inputs();
    step();
    step();
    vectors++;
    if (bus.phase !== 3'd3 || bus.RegWrite !== 1'b0 || bus.pending_mask !== 32'h3000) begin
      miscompares++;
      $display("FAIL rst_before_grant: phase=%0d RegWrite=%0b mask=%h required 3 0 00003000",
               bus.phase, bus.RegWrite, bus.pending_mask);
    end
    step();
    vectors++;
    if (bus.RegWrite !== 1'b1 || bus.write_register !== 5'd13 || bus.write_data !== 32'hC13) begin
      miscompares++;
      $display("FAIL rst_first_grant: RegWrite=%0b wr=%0d wd=%h required 1 13 00000c13",
               bus.RegWrite, bus.write_register, bus.write_data);
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_tie();
    test_backpressure();
    test_zero_reg();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
